// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster scan generator.
package vga_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_CLK_DIV   = 2;

    function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, terminal count, and registered
// sync-window / visible-region decode aligned with the count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL   = 800,
    parameter int VISIBLE = 640,
    parameter int WIN_LO  = 656,
    parameter int WIN_HI  = 752
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_en,
    output coord_t o_cnt,
    output logic   o_tc,
    output logic   o_sync_n,
    output logic   o_vis
);

    localparam coord_t C_LAST = coord_t'(TOTAL - 1);
    localparam coord_t C_VIS  = coord_t'(VISIBLE);
    localparam coord_t C_WLO  = coord_t'(WIN_LO);
    localparam coord_t C_WHI  = coord_t'(WIN_HI);

    coord_t r_cnt;
    coord_t w_cnt_next;
    logic   r_sync_n;
    logic   r_vis;
    logic   w_tc;

    assign w_tc = (r_cnt == C_LAST);

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_en) begin
            w_cnt_next = w_tc ? '0 : r_cnt + coord_t'(1);
        end
    end

    // Decode the next count so the flags change on the same edge as the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_sync_n <= 1'b1;
            r_vis    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_sync_n <= !((w_cnt_next >= C_WLO) && (w_cnt_next < C_WHI));
            r_vis    <= (w_cnt_next < C_VIS);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_tc     = w_tc;
    assign o_sync_n = r_sync_n;
    assign o_vis    = r_vis;

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator and VGA pin driver. Define VGA_OUT_REG_EN to register
// the colour and sync pins one pixel behind DrawX/DrawY.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Red,
    input  logic [7:0] Green,
    input  logic [7:0] Blue,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       frame_start,
    output logic       pix_en,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOT = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    if (H_TOT > COORD_MAX) begin : g_h_too_wide
        $error("vga_scan_gen: horizontal total %0d exceeds 10-bit counter", H_TOT);
    end
    if (V_TOT > COORD_MAX) begin : g_v_too_wide
        $error("vga_scan_gen: vertical total %0d exceeds 10-bit counter", V_TOT);
    end
    if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0)) begin : g_bad_div
        $error("vga_scan_gen: CLK_DIV %0d must be even and at least 2", CLK_DIV);
    end

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic             r_vga_clk;
    logic             w_pix_en;

    assign w_pix_en = (r_div == DIV_LAST);

    always_comb begin
        w_div_next = r_div + DIV_W'(1);
        if (w_pix_en) begin
            w_div_next = '0;
        end
    end

    // VGA_CLK is registered from the next divider value to keep the DAC clock glitch-free.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div     <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_vga_clk <= (w_div_next >= DIV_HALF);
        end
    end

    coord_t w_hc;
    coord_t w_vc;
    logic   w_h_tc;
    logic   w_v_tc;
    logic   w_h_sync_n;
    logic   w_v_sync_n;
    logic   w_h_vis;
    logic   w_v_vis;
    logic   w_v_en;

    assign w_v_en = w_pix_en & w_h_tc;

    vga_axis_counter #(
        .TOTAL   (H_TOT),
        .VISIBLE (H_VISIBLE),
        .WIN_LO  (H_VISIBLE + H_FP),
        .WIN_HI  (H_VISIBLE + H_FP + H_SYNC)
    ) u_h_axis (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_en     (w_pix_en),
        .o_cnt    (w_hc),
        .o_tc     (w_h_tc),
        .o_sync_n (w_h_sync_n),
        .o_vis    (w_h_vis)
    );

    vga_axis_counter #(
        .TOTAL   (V_TOT),
        .VISIBLE (V_VISIBLE),
        .WIN_LO  (V_VISIBLE + V_FP),
        .WIN_HI  (V_VISIBLE + V_FP + V_SYNC)
    ) u_v_axis (
        .i_clk    (Clk),
        .i_rst_n  (Reset_n),
        .i_en     (w_v_en),
        .o_cnt    (w_vc),
        .o_tc     (w_v_tc),
        .o_sync_n (w_v_sync_n),
        .o_vis    (w_v_vis)
    );

    logic w_blank_n;
    rgb_t w_rgb_in;
    rgb_t w_rgb_out;
    logic w_hs_out;
    logic w_vs_out;
    logic w_blank_n_out;

    assign w_blank_n = w_h_vis & w_v_vis;
    assign w_rgb_in  = {Red, Green, Blue};

`ifdef VGA_OUT_REG_EN
    logic r_hs;
    logic r_vs;
    logic r_blank_n;
    rgb_t r_rgb;

    // Colour and sync share one pixel-wide pipeline stage so the pins stay aligned.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (w_pix_en) begin
            r_hs      <= w_h_sync_n;
            r_vs      <= w_v_sync_n;
            r_blank_n <= w_blank_n;
            r_rgb     <= w_rgb_in;
        end
    end

    assign w_hs_out      = r_hs;
    assign w_vs_out      = r_vs;
    assign w_blank_n_out = r_blank_n;
    assign w_rgb_out     = r_blank_n ? r_rgb : '0;
`else
    assign w_hs_out      = w_h_sync_n;
    assign w_vs_out      = w_v_sync_n;
    assign w_blank_n_out = w_blank_n;
    assign w_rgb_out     = w_blank_n ? w_rgb_in : '0;
`endif

    assign DrawX       = w_hc;
    assign DrawY       = w_vc;
    assign pix_en      = w_pix_en;
    assign frame_start = w_pix_en & w_h_tc & w_v_tc;
    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = w_hs_out;
    assign VGA_VS      = w_vs_out;
    assign VGA_BLANK_N = w_blank_n_out;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = w_rgb_out.r;
    assign VGA_G       = w_rgb_out.g;
    assign VGA_B       = w_rgb_out.b;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default 640x480 instance and a small-timing
// instance (CLK_DIV=4) checked cycle by cycle against a timing model.
module tb_vga_scan_gen;
    import vga_pkg::*;

    localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VV = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_DIV = 4;

    localparam int I_HV = 0, I_HF = 1, I_HS = 2, I_HB = 3;
    localparam int I_VV = 4, I_VF = 5, I_VS = 6, I_VB = 7, I_DIV = 8;
    localparam int TIM [2][9] = '{
        '{640, 16, 96, 48, 480, 10, 2, 33, 2},
        '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, S_DIV}
    };

`ifdef VGA_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pix_en;
        logic       fs;
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [7:0] Red = 8'hAA, Green = 8'h55, Blue = 8'hFF;

    coord_t     d_DrawX, d_DrawY, s_DrawX, s_DrawY;
    logic       d_frame_start, d_pix_en, d_VGA_CLK, d_VGA_HS, d_VGA_VS, d_VGA_BLANK_N, d_VGA_SYNC_N;
    logic       s_frame_start, s_pix_en, s_VGA_CLK, s_VGA_HS, s_VGA_VS, s_VGA_BLANK_N, s_VGA_SYNC_N;
    logic [7:0] d_VGA_R, d_VGA_G, d_VGA_B, s_VGA_R, s_VGA_G, s_VGA_B;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;
    exp_t m_reg_d, m_reg_s;
    logic [EXP_W-1:0] d_exp_q[$];
    logic [EXP_W-1:0] s_exp_q[$];

    always #5 Clk = ~Clk;

    vga_scan_gen u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
        .DrawX(d_DrawX), .DrawY(d_DrawY), .frame_start(d_frame_start), .pix_en(d_pix_en),
        .VGA_CLK(d_VGA_CLK), .VGA_HS(d_VGA_HS), .VGA_VS(d_VGA_VS), .VGA_BLANK_N(d_VGA_BLANK_N),
        .VGA_SYNC_N(d_VGA_SYNC_N), .VGA_R(d_VGA_R), .VGA_G(d_VGA_G), .VGA_B(d_VGA_B)
    );

    vga_scan_gen #(
        .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .CLK_DIV(S_DIV)
    ) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .Red(Red), .Green(Green), .Blue(Blue),
        .DrawX(s_DrawX), .DrawY(s_DrawY), .frame_start(s_frame_start), .pix_en(s_pix_en),
        .VGA_CLK(s_VGA_CLK), .VGA_HS(s_VGA_HS), .VGA_VS(s_VGA_VS), .VGA_BLANK_N(s_VGA_BLANK_N),
        .VGA_SYNC_N(s_VGA_SYNC_N), .VGA_R(s_VGA_R), .VGA_G(s_VGA_G), .VGA_B(s_VGA_B)
    );

    function automatic int ht(input int sm);
        return TIM[sm][I_HV] + TIM[sm][I_HF] + TIM[sm][I_HS] + TIM[sm][I_HB];
    endfunction

    function automatic int vt(input int sm);
        return TIM[sm][I_VV] + TIM[sm][I_VF] + TIM[sm][I_VS] + TIM[sm][I_VB];
    endfunction

    function automatic exp_t reset_pins();
        exp_t e;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Pin values for pixel p of the scan, using the colour currently driven.
    function automatic exp_t pix_decode(input int sm, input int p);
        exp_t e;
        int hc, vc, h_lo, v_lo;
        e = '0;
        hc = p % ht(sm);
        vc = (p / ht(sm)) % vt(sm);
        h_lo = TIM[sm][I_HV] + TIM[sm][I_HF];
        v_lo = TIM[sm][I_VV] + TIM[sm][I_VF];
        e.x = 10'(hc);
        e.y = 10'(vc);
        e.hs = !((hc >= h_lo) && (hc < h_lo + TIM[sm][I_HS]));
        e.vs = !((vc >= v_lo) && (vc < v_lo + TIM[sm][I_VS]));
        e.blank_n = (hc < TIM[sm][I_HV]) && (vc < TIM[sm][I_VV]);
        if (e.blank_n) begin
            e.r = Red;
            e.g = Green;
            e.b = Blue;
        end
        return e;
    endfunction

    function automatic bit is_pix(input int sm, input int kk);
        return (kk % TIM[sm][I_DIV]) == (TIM[sm][I_DIV] - 1);
    endfunction

    function automatic exp_t cyc_model(input int sm, input int kk);
        exp_t e, cur;
        int dv, div;
        dv  = TIM[sm][I_DIV];
        div = kk % dv;
        cur = pix_decode(sm, kk / dv);
        if (LAT == 0) e = cur;
        else e = (sm == 0) ? m_reg_d : m_reg_s;
        e.x = cur.x;
        e.y = cur.y;
        e.pix_en = (div == dv - 1);
        e.fs = e.pix_en && (int'(cur.x) == ht(sm) - 1) && (int'(cur.y) == vt(sm) - 1);
        e.vclk = (div >= dv / 2);
        return e;
    endfunction

    function automatic exp_t got_d();
        return {d_DrawX, d_DrawY, d_pix_en, d_frame_start, d_VGA_CLK, d_VGA_HS, d_VGA_VS,
                d_VGA_BLANK_N, d_VGA_R, d_VGA_G, d_VGA_B};
    endfunction

    function automatic exp_t got_s();
        return {s_DrawX, s_DrawY, s_pix_en, s_frame_start, s_VGA_CLK, s_VGA_HS, s_VGA_VS,
                s_VGA_BLANK_N, s_VGA_R, s_VGA_G, s_VGA_B};
    endfunction

    // Advance one Clk: push the expected outputs for the coming cycle, then sample point.
    task automatic step();
        if (is_pix(0, k)) m_reg_d = pix_decode(0, k / TIM[0][I_DIV]);
        if (is_pix(1, k)) m_reg_s = pix_decode(1, k / TIM[1][I_DIV]);
        k++;
        d_exp_q.push_back(cyc_model(0, k));
        s_exp_q.push_back(cyc_model(1, k));
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic restart_model();
        k = 0;
        m_reg_d = reset_pins();
        m_reg_s = reset_pins();
        d_exp_q.delete();
        s_exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        restart_model();
    endtask

    task automatic test_reset();
        exp_t rst_exp;
        rst_exp = reset_pins();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (got_d() !== rst_exp) begin
            n_errors++;
            $display("FAIL reset_d got=%h exp=%h", got_d(), rst_exp);
        end
        n_checks++;
        if (got_s() !== rst_exp) begin
            n_errors++;
            $display("FAIL reset_s got=%h exp=%h", got_s(), rst_exp);
        end
        n_checks++;
        if ({d_VGA_SYNC_N, s_VGA_SYNC_N} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_sync_n got=%b%b exp=00", d_VGA_SYNC_N, s_VGA_SYNC_N);
        end
    endtask

    task automatic test_line();
        exp_t e_d, e_s;
        int hs_low, first_hs_x, blank_fall_x;
        bit seen_vis, seen_y1;
        hs_low = 0; first_hs_x = -1; blank_fall_x = -1; seen_vis = 0; seen_y1 = 0;
        Red = 8'hAA; Green = 8'h55; Blue = 8'hFF;
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            step();
            e_d = exp_t'(d_exp_q.pop_front());
            e_s = exp_t'(s_exp_q.pop_front());
            n_checks++;
            if (got_d() !== e_d) begin
                n_errors++;
                $display("FAIL line_d k=%0d got=%h exp=%h", k, got_d(), e_d);
            end
            n_checks++;
            if (got_s() !== e_s) begin
                n_errors++;
                $display("FAIL line_s k=%0d got=%h exp=%h", k, got_s(), e_s);
            end
            if (k <= 800 * TIM[0][I_DIV] && d_VGA_HS === 1'b0) begin
                hs_low++;
                if (first_hs_x < 0) first_hs_x = int'(d_DrawX);
            end
            if (d_VGA_BLANK_N === 1'b1) seen_vis = 1;
            if (seen_vis && d_VGA_BLANK_N === 1'b0 && blank_fall_x < 0) blank_fall_x = int'(d_DrawX);
            if (!seen_y1 && d_DrawY == 10'd1) begin
                seen_y1 = 1;
                n_checks++;
                if (d_DrawX !== 10'd0) begin
                    n_errors++;
                    $display("FAIL line_wrap_x got=%0d exp=0", d_DrawX);
                end
            end
        end
        n_checks++;
        if (hs_low != 96 * TIM[0][I_DIV]) begin
            n_errors++;
            $display("FAIL hs_low_cycles got=%0d exp=%0d", hs_low, 96 * TIM[0][I_DIV]);
        end
        n_checks++;
        if (first_hs_x != 656 + LAT) begin
            n_errors++;
            $display("FAIL hs_first_x got=%0d exp=%0d", first_hs_x, 656 + LAT);
        end
        n_checks++;
        if (blank_fall_x != 640 + LAT) begin
            n_errors++;
            $display("FAIL blank_fall_x got=%0d exp=%0d", blank_fall_x, 640 + LAT);
        end
        n_checks++;
        if (!seen_y1) begin
            n_errors++;
            $display("FAIL line_y_step got=0 exp=1");
        end
    endtask

    task automatic test_frame();
        exp_t e_d, e_s;
        int fs_cnt, vs_low, first_vs_y;
        bit after_fs;
        fs_cnt = 0; vs_low = 0; first_vs_y = -1; after_fs = 0;
        Red = 8'(($urandom_range(0, 254))); Green = 8'h3C; Blue = 8'hC3;
        do_reset();
        for (int i = 0; i < 3020; i++) begin
            step();
            e_d = exp_t'(d_exp_q.pop_front());
            e_s = exp_t'(s_exp_q.pop_front());
            n_checks++;
            if (got_d() !== e_d) begin
                n_errors++;
                $display("FAIL frame_d k=%0d got=%h exp=%h", k, got_d(), e_d);
            end
            n_checks++;
            if (got_s() !== e_s) begin
                n_errors++;
                $display("FAIL frame_s k=%0d got=%h exp=%h", k, got_s(), e_s);
            end
            if (after_fs) begin
                after_fs = 0;
                n_checks++;
                if ({s_DrawX, s_DrawY} !== 20'd0) begin
                    n_errors++;
                    $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", s_DrawX, s_DrawY);
                end
            end
            if (s_frame_start === 1'b1) begin
                fs_cnt++;
                after_fs = 1;
            end
            if (s_VGA_VS === 1'b0) begin
                vs_low++;
                if (first_vs_y < 0) first_vs_y = int'(s_DrawY);
            end
        end
        n_checks++;
        if (fs_cnt != 2) begin
            n_errors++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
        n_checks++;
        if (vs_low != 2 * S_VS * ht(1) * S_DIV) begin
            n_errors++;
            $display("FAIL vs_low_cycles got=%0d exp=%0d", vs_low, 2 * S_VS * ht(1) * S_DIV);
        end
        n_checks++;
        if (first_vs_y != S_VV + S_VF) begin
            n_errors++;
            $display("FAIL vs_first_y got=%0d exp=%0d", first_vs_y, S_VV + S_VF);
        end
    endtask

    task automatic test_colour();
        exp_t e_d, e_s;
        Red = 8'hAA; Green = 8'h55; Blue = 8'hFF;
        do_reset();
        for (int i = 0; i < 2100; i++) begin
            if (i >= 1700 && (i % 38) == 0) begin
                Red   = 8'($urandom_range(0, 255));
                Green = 8'($urandom_range(0, 255));
                Blue  = 8'($urandom_range(0, 255));
            end
            step();
            e_d = exp_t'(d_exp_q.pop_front());
            e_s = exp_t'(s_exp_q.pop_front());
            n_checks++;
            if (got_d() !== e_d) begin
                n_errors++;
                $display("FAIL colour_d k=%0d got=%h exp=%h", k, got_d(), e_d);
            end
            n_checks++;
            if (got_s() !== e_s) begin
                n_errors++;
                $display("FAIL colour_s k=%0d got=%h exp=%h", k, got_s(), e_s);
            end
            if (d_VGA_BLANK_N === 1'b0) begin
                n_checks++;
                if ({d_VGA_R, d_VGA_G, d_VGA_B} !== 24'h0) begin
                    n_errors++;
                    $display("FAIL colour_blanked k=%0d got=%h exp=000000", k, {d_VGA_R, d_VGA_G, d_VGA_B});
                end
            end else if (i < 1700) begin
                n_checks++;
                if ({d_VGA_R, d_VGA_G, d_VGA_B} !== 24'hAA55FF) begin
                    n_errors++;
                    $display("FAIL colour_visible k=%0d got=%h exp=aa55ff", k, {d_VGA_R, d_VGA_G, d_VGA_B});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e_d, e_s, rst_exp;
        rst_exp = reset_pins();
        Red = 8'h12; Green = 8'h34; Blue = 8'h56;
        do_reset();
        for (int i = 0; i < 135 * S_DIV + S_DIV - 1; i++) begin
            step();
            e_d = exp_t'(d_exp_q.pop_front());
            e_s = exp_t'(s_exp_q.pop_front());
            n_checks++;
            if (got_d() !== e_d) begin
                n_errors++;
                $display("FAIL pre_reset_d k=%0d got=%h exp=%h", k, got_d(), e_d);
            end
            n_checks++;
            if (got_s() !== e_s) begin
                n_errors++;
                $display("FAIL pre_reset_s k=%0d got=%h exp=%h", k, got_s(), e_s);
            end
        end
        n_checks++;
        if ({s_DrawX, s_DrawY} !== {10'd10, 10'd5}) begin
            n_errors++;
            $display("FAIL mid_frame_pos got=(%0d,%0d) exp=(10,5)", s_DrawX, s_DrawY);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if (got_d() !== rst_exp) begin
            n_errors++;
            $display("FAIL async_reset_d got=%h exp=%h", got_d(), rst_exp);
        end
        n_checks++;
        if (got_s() !== rst_exp) begin
            n_errors++;
            $display("FAIL async_reset_s got=%h exp=%h", got_s(), rst_exp);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        restart_model();
        for (int i = 0; i < 400; i++) begin
            step();
            e_d = exp_t'(d_exp_q.pop_front());
            e_s = exp_t'(s_exp_q.pop_front());
            if (i == 0) begin
                n_checks++;
                if ({d_DrawX, d_DrawY, s_DrawX, s_DrawY} !== 40'd0) begin
                    n_errors++;
                    $display("FAIL restart_origin got=(%0d,%0d)/(%0d,%0d) exp=(0,0)",
                             d_DrawX, d_DrawY, s_DrawX, s_DrawY);
                end
            end
            n_checks++;
            if (got_d() !== e_d) begin
                n_errors++;
                $display("FAIL post_reset_d k=%0d got=%h exp=%h", k, got_d(), e_d);
            end
            n_checks++;
            if (got_s() !== e_s) begin
                n_errors++;
                $display("FAIL post_reset_s k=%0d got=%h exp=%h", k, got_s(), e_s);
            end
        end
    endtask

    initial begin
        restart_model();
        test_reset();
        test_line();
        test_frame();
        test_colour();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
